brv32p_mem_arbiter: RTL and testbench

//  Shares one 32-bit word-addressed memory bus between the core's instruction and data ports.

---
 rtl/brv32p_pkg.sv | 52 +++++
 rtl/dmem_lane_steer.sv | 28 ++
 rtl/brv32p_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_brv32p_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/brv32p_pkg.sv
// Shared types and helpers for the brv32p memory path: access widths, arbiter states,
// byte-enable generation, load lane extraction/extension and misalignment detection.
package brv32p_pkg;

  typedef enum logic [1:0] {
    MW_BYTE = 2'd0,
    MW_HALF = 2'd1,
    MW_WORD = 2'd2
  } mem_width_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IFETCH,
    ST_IFETCH_HI,
    ST_DACC,
    ST_RESP_I,
    ST_RESP_D
  } arb_state_e;

  // Low two bits of a halfword equal to 2'b11 mark the start of a 32-bit instruction.
  localparam logic [1:0] INSN_32B = 2'b11;

  function automatic logic [3:0] be_gen(input mem_width_e width, input logic [1:0] a);
    case (width)
      MW_BYTE: be_gen = 4'b0001 << a;
      MW_HALF: be_gen = 4'b0011 << {a[1], 1'b0};
      default: be_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input mem_width_e width,
                                              input logic [1:0] a, input logic sext);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = word[{a, 3'b000} +: 8];
    lane_h = word[{a[1], 4'b0000} +: 16];
    case (width)
      MW_BYTE: load_extend = {{24{sext & lane_b[7]}}, lane_b};
      MW_HALF: load_extend = {{16{sext & lane_h[15]}}, lane_h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic misaligned(input mem_width_e width, input logic [1:0] a);
    case (width)
      MW_BYTE: misaligned = 1'b0;
      MW_HALF: misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Combinational byte-lane steering for data accesses: byte enables, store-data replication,
// load lane extraction with sign/zero extension, and misalignment flag.
import brv32p_pkg::*;

module dmem_lane_steer (
  input  mem_width_e  width_i,
  input  logic [1:0]  offset_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  always_comb begin
    be_o       = be_gen(width_i, offset_i);
    rdata_o    = load_extend(rword_i, width_i, offset_i, sext_i);
    misalign_o = misaligned(width_i, offset_i);
    case (width_i)
      MW_BYTE: wdata_o = {4{wdata_i[7:0]}};
      MW_HALF: wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/brv32p_mem_arbiter.sv
// Shares one word bus between instruction fetch and data ports. States: IDLE arbitrate |
// IFETCH first fetch word | IFETCH_HI upper word of split fetch | DACC data beat | RESP_I/RESP_D ready pulse.
import brv32p_pkg::*;

module brv32p_mem_arbiter #(
  parameter int STARVE_LIMIT  = 4,
  parameter bit DMEM_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr_i,
  input  logic        imem_rd_i,
  output logic [31:0] imem_rdata_o,
  output logic        imem_ready_o,
  input  logic [31:0] dmem_addr_i,
  input  logic        dmem_rd_i,
  input  logic        dmem_wr_i,
  input  mem_width_e  dmem_width_i,
  input  logic        dmem_sign_ext_i,
  input  logic [31:0] dmem_wdata_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_ready_o,
  output logic        dmem_misalign_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e  state_q;
  logic [SW-1:0] starve_q, starve_d;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic        imem_ready_q, dmem_ready_q, dmem_misalign_q;
  logic [31:0] imem_rdata_q, dmem_rdata_q;
  logic        fetch_hi_q;
  logic [15:0] half_q;

  logic        dmem_req, starve_hit, pick_d, pick_i;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, st_rdata;
  logic        st_misalign;
  logic        unused_addr_bit;

  assign unused_addr_bit = imem_addr_i[0];

  dmem_lane_steer u_steer (
    .width_i    (dmem_width_i),
    .offset_i   (dmem_addr_i[1:0]),
    .sext_i     (dmem_sign_ext_i),
    .wdata_i    (dmem_wdata_i),
    .rword_i    (bus_rdata_i),
    .be_o       (st_be),
    .wdata_o    (st_wdata),
    .rdata_o    (st_rdata),
    .misalign_o (st_misalign)
  );

  always_comb begin
    dmem_req   = dmem_rd_i | dmem_wr_i;
    starve_hit = (starve_q == SW'(STARVE_LIMIT));
    pick_d     = dmem_req && (!imem_rd_i || (DMEM_PRIORITY && !starve_hit));
    pick_i     = imem_rd_i && !pick_d;
    starve_d   = starve_q;
    if (pick_i)
      starve_d = '0;
    else if (pick_d && imem_rd_i && !starve_hit)
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      starve_q        <= '0;
      bus_req_q       <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      bus_be_q        <= '0;
      imem_ready_q    <= 1'b0;
      dmem_ready_q    <= 1'b0;
      dmem_misalign_q <= 1'b0;
      imem_rdata_q    <= '0;
      dmem_rdata_q    <= '0;
      fetch_hi_q      <= 1'b0;
      half_q          <= '0;
    end else begin
      imem_ready_q    <= 1'b0;
      dmem_ready_q    <= 1'b0;
      dmem_misalign_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          starve_q <= starve_d;
          if (pick_d) begin
            if (st_misalign) begin
              state_q         <= ST_RESP_D;
              dmem_ready_q    <= 1'b1;
              dmem_misalign_q <= 1'b1;
              dmem_rdata_q    <= '0;
            end else begin
              state_q     <= ST_DACC;
              bus_req_q   <= 1'b1;
              bus_addr_q  <= {dmem_addr_i[31:2], 2'b00};
              bus_we_q    <= dmem_wr_i;
              bus_be_q    <= st_be;
              bus_wdata_q <= dmem_wr_i ? st_wdata : '0;
            end
          end else if (pick_i) begin
            state_q     <= ST_IFETCH;
            bus_req_q   <= 1'b1;
            bus_addr_q  <= {imem_addr_i[31:2], 2'b00};
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'b1111;
            bus_wdata_q <= '0;
            fetch_hi_q  <= imem_addr_i[1];
          end
        end
        ST_IFETCH: begin
          if (bus_ack_i) begin
            if (fetch_hi_q && bus_rdata_i[17:16] == INSN_32B) begin
              // Second beat fetches the next word; wraps through zero at the top of memory.
              state_q    <= ST_IFETCH_HI;
              half_q     <= bus_rdata_i[31:16];
              bus_addr_q <= bus_addr_q + 32'd4;
            end else begin
              state_q      <= ST_RESP_I;
              imem_ready_q <= 1'b1;
              imem_rdata_q <= fetch_hi_q ? {16'h0000, bus_rdata_i[31:16]} : bus_rdata_i;
              bus_req_q    <= 1'b0;
              bus_be_q     <= '0;
            end
          end
        end
        ST_IFETCH_HI: begin
          if (bus_ack_i) begin
            state_q      <= ST_RESP_I;
            imem_ready_q <= 1'b1;
            imem_rdata_q <= {bus_rdata_i[15:0], half_q};
            bus_req_q    <= 1'b0;
            bus_be_q     <= '0;
          end
        end
        ST_DACC: begin
          if (bus_ack_i) begin
            state_q      <= ST_RESP_D;
            dmem_ready_q <= 1'b1;
            dmem_rdata_q <= bus_we_q ? '0 : st_rdata;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_be_q     <= '0;
          end
        end
        ST_RESP_I, ST_RESP_D: state_q <= ST_IDLE;
        default:              state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_rdata_o    = imem_rdata_q;
  assign imem_ready_o    = imem_ready_q;
  assign dmem_rdata_o    = dmem_rdata_q;
  assign dmem_ready_o    = dmem_ready_q;
  assign dmem_misalign_o = dmem_misalign_q;
  assign bus_req_o       = bus_req_q;
  assign bus_addr_o      = bus_addr_q;
  assign bus_we_o        = bus_we_q;
  assign bus_be_o        = bus_be_q;
  assign bus_wdata_o     = bus_wdata_q;

endmodule

// File: tb/tb_brv32p_mem_arbiter.sv
// Directed bench for brv32p_mem_arbiter: a combinational bus responder plus hand-computed
// expectations for loads, stores, split fetches, arbitration, wait states and reset.
module tb_brv32p_mem_arbiter;
  import brv32p_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        imem_rd, imem_ready, dmem_rd, dmem_wr, dmem_sign_ext, dmem_ready, dmem_misalign;
  mem_width_e  dmem_width;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  logic        ack_en;
  logic [31:0] lo_word, hi_word, hi_addr;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          lat, beats;
  logic [31:0] b_addr [2];
  logic [31:0] b_wdata;
  logic [3:0]  b_be;
  logic        b_we, saw_req, mis;

  always #5 clk = ~clk;

  assign bus_ack   = bus_req & ack_en;
  assign bus_rdata = (bus_addr == hi_addr) ? hi_word : lo_word;

  brv32p_mem_arbiter #(.STARVE_LIMIT(4), .DMEM_PRIORITY(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr_i     (imem_addr),
    .imem_rd_i       (imem_rd),
    .imem_rdata_o    (imem_rdata),
    .imem_ready_o    (imem_ready),
    .dmem_addr_i     (dmem_addr),
    .dmem_rd_i       (dmem_rd),
    .dmem_wr_i       (dmem_wr),
    .dmem_width_i    (dmem_width),
    .dmem_sign_ext_i (dmem_sign_ext),
    .dmem_wdata_i    (dmem_wdata),
    .dmem_rdata_o    (dmem_rdata),
    .dmem_ready_o    (dmem_ready),
    .dmem_misalign_o (dmem_misalign),
    .bus_req_o       (bus_req),
    .bus_addr_o      (bus_addr),
    .bus_we_o        (bus_we),
    .bus_be_o        (bus_be),
    .bus_wdata_o     (bus_wdata),
    .bus_rdata_i     (bus_rdata),
    .bus_ack_i       (bus_ack)
  );

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h want %08h", tag, act, exp);
    end
  endtask

  task automatic idle_all();
    dmem_rd = 1'b0;
    dmem_wr = 1'b0;
    imem_rd = 1'b0;
  endtask

  // Waits (bounded) for the ready pulse of one port, logging bus beats on the way.
  task automatic run_req(input bit port_d);
    lat = -1; beats = 0; saw_req = 1'b0; mis = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_req) saw_req = 1'b1;
      if (bus_req && bus_ack) begin
        if (beats < 2) b_addr[beats] = bus_addr;
        b_be = bus_be; b_we = bus_we; b_wdata = bus_wdata;
        beats++;
      end
      if (port_d ? dmem_ready : imem_ready) begin
        lat = c;
        mis = dmem_misalign;
        break;
      end
    end
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic d_access(input logic rd, input logic wr, input logic [31:0] addr,
                          input mem_width_e w, input logic sext, input logic [31:0] wd);
    dmem_rd = rd; dmem_wr = wr; dmem_addr = addr; dmem_width = w;
    dmem_sign_ext = sext; dmem_wdata = wd;
    run_req(1'b1);
  endtask

  task automatic i_access(input logic [31:0] addr);
    imem_addr = addr; imem_rd = 1'b1;
    run_req(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] seq;
    int n, pulses;
    idle_all();
    imem_addr = '0; dmem_addr = '0; dmem_width = MW_WORD; dmem_sign_ext = 1'b0; dmem_wdata = '0;
    ack_en = 1'b1; lo_word = '0; hi_word = '0; hi_addr = 32'h1;

    repeat (2) @(negedge clk);
    check_vec("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check_vec("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check_vec("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check_vec("rst_irdy", {31'd0, imem_ready}, 32'd0);
    check_vec("rst_drdy", {31'd0, dmem_ready}, 32'd0);
    check_vec("rst_mis", {31'd0, dmem_misalign}, 32'd0);
    check_vec("rst_irdata", imem_rdata, 32'd0);
    check_vec("rst_drdata", dmem_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    lo_word = 32'hDEAD_BEEF;
    d_access(1'b1, 1'b0, 32'h100, MW_WORD, 1'b0, 32'h0);
    check_vec("lw_lat", lat, 32'd2);
    check_vec("lw_rdata", dmem_rdata, 32'hDEAD_BEEF);
    check_vec("lw_be", {28'd0, b_be}, 32'hF);
    check_vec("lw_addr", b_addr[0], 32'h100);
    check_vec("lw_beats", beats, 32'd1);
    check_vec("lw_we", {31'd0, b_we}, 32'd0);
    check_vec("lw_mis", {31'd0, mis}, 32'd0);

    d_access(1'b0, 1'b1, 32'h203, MW_BYTE, 1'b0, 32'h0000_00A5);
    check_vec("sb_addr", b_addr[0], 32'h200);
    check_vec("sb_be", {28'd0, b_be}, 32'h8);
    check_vec("sb_wdata", b_wdata, 32'hA5A5_A5A5);
    check_vec("sb_we", {31'd0, b_we}, 32'd1);
    check_vec("sb_lat", lat, 32'd2);

    lo_word = 32'h8001_0000;
    d_access(1'b1, 1'b0, 32'h302, MW_HALF, 1'b1, 32'h0);
    check_vec("lh_s_rdata", dmem_rdata, 32'hFFFF_8001);
    check_vec("lh_be", {28'd0, b_be}, 32'hC);
    d_access(1'b1, 1'b0, 32'h302, MW_HALF, 1'b0, 32'h0);
    check_vec("lhu_rdata", dmem_rdata, 32'h0000_8001);

    lo_word = 32'h0000_8000;
    d_access(1'b1, 1'b0, 32'h101, MW_BYTE, 1'b1, 32'h0);
    check_vec("lb_s_rdata", dmem_rdata, 32'hFFFF_FF80);
    check_vec("lb_be", {28'd0, b_be}, 32'h2);

    d_access(1'b0, 1'b1, 32'h206, MW_HALF, 1'b0, 32'h1234_ABCD);
    check_vec("sh_addr", b_addr[0], 32'h204);
    check_vec("sh_be", {28'd0, b_be}, 32'hC);
    check_vec("sh_wdata", b_wdata, 32'hABCD_ABCD);

    lo_word = 32'h00B3_0000; hi_addr = 32'h404; hi_word = 32'h0000_1234;
    i_access(32'h402);
    check_vec("split_lat", lat, 32'd3);
    check_vec("split_beats", beats, 32'd2);
    check_vec("split_addr0", b_addr[0], 32'h400);
    check_vec("split_addr1", b_addr[1], 32'h404);
    check_vec("split_rdata", imem_rdata, 32'h1234_00B3);

    lo_word = 32'h4501_0000; hi_addr = 32'h1;
    i_access(32'h402);
    check_vec("rvc_beats", beats, 32'd1);
    check_vec("rvc_lat", lat, 32'd2);
    check_vec("rvc_rdata", imem_rdata, 32'h0000_4501);

    lo_word = 32'h1234_5678;
    i_access(32'h500);
    check_vec("if_rdata", imem_rdata, 32'h1234_5678);
    check_vec("if_lat", lat, 32'd2);

    lo_word = 32'h0013_0000; hi_addr = 32'h0; hi_word = 32'h0000_ABCD;
    i_access(32'hFFFF_FFFE);
    check_vec("wrap_addr0", b_addr[0], 32'hFFFF_FFFC);
    check_vec("wrap_addr1", b_addr[1], 32'h0);
    check_vec("wrap_rdata", imem_rdata, 32'hABCD_0013);
    hi_addr = 32'h1;

    d_access(1'b1, 1'b0, 32'h101, MW_WORD, 1'b0, 32'h0);
    check_vec("mis_w_req", {31'd0, saw_req}, 32'd0);
    check_vec("mis_w_flag", {31'd0, mis}, 32'd1);
    check_vec("mis_w_lat", lat, 32'd1);
    check_vec("mis_w_rdata", dmem_rdata, 32'd0);
    d_access(1'b1, 1'b0, 32'h303, MW_HALF, 1'b0, 32'h0);
    check_vec("mis_h_flag", {31'd0, mis}, 32'd1);
    check_vec("mis_h_req", {31'd0, saw_req}, 32'd0);

    imem_addr = 32'h600; imem_rd = 1'b1;
    dmem_addr = 32'h700; dmem_rd = 1'b1; dmem_width = MW_WORD;
    seq = '0; n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus_req && bus_ack) begin
        if (n < 10) seq[n] = (bus_addr == 32'h700);
        n++;
      end
      if (n >= 10 && imem_ready) break;
    end
    @(posedge clk); #1;
    idle_all();
    check_vec("starve_beats", n, 32'd10);
    check_vec("starve_seq", {22'd0, seq}, 32'b01_1110_1111);

    ack_en = 1'b0;
    dmem_addr = 32'h800; dmem_wr = 1'b1; dmem_width = MW_WORD; dmem_wdata = 32'h1122_3344;
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_vec("hold_req", {31'd0, bus_req}, 32'd1);
      check_vec("hold_addr", bus_addr, 32'h800);
      check_vec("hold_wdata", bus_wdata, 32'h1122_3344);
      check_vec("hold_be", {28'd0, bus_be}, 32'hF);
      check_vec("hold_rdy", {31'd0, dmem_ready}, 32'd0);
    end
    ack_en = 1'b1;
    @(negedge clk);
    check_vec("hold_done", {31'd0, dmem_ready}, 32'd1);
    @(posedge clk); #1;
    idle_all();

    ack_en = 1'b0;
    dmem_addr = 32'h900; dmem_rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_vec("rstbeat_req", {31'd0, bus_req}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_vec("rstbeat_drop", {31'd0, bus_req}, 32'd0);
    check_vec("rstbeat_be", {28'd0, bus_be}, 32'd0);
    idle_all();
    ack_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (dmem_ready || imem_ready) pulses++;
    end
    check_vec("rstbeat_nordy", pulses, 32'd0);
    @(posedge clk); #1;
    lo_word = 32'hCAFE_F00D;
    d_access(1'b1, 1'b0, 32'hA00, MW_WORD, 1'b0, 32'h0);
    check_vec("reissue_lat", lat, 32'd2);
    check_vec("reissue_rdata", dmem_rdata, 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
